// File: rtl/mult_div_control_unit_if.sv
// Control-unit handshake and strobe bundle between the sequencer and the 32-bit datapath.
// The master side drives Run, Mem_ready and IR. The slave side drives the strobes.
interface mult_div_control_unit_if;
    logic        Run;
    logic        Mem_ready;
    logic [31:0] IR;
    logic        PCout, MDRout, Zhiout, Zlowout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic        IncPC, Read;
    logic        ADD, SUB, AND, OR, MUL, DIV;
    logic [15:0] Rout, Rin;
    logic        Done, Illegal;

    modport master (
        output Run, Mem_ready, IR,
        input  PCout, MDRout, Zhiout, Zlowout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        input  IncPC, Read, ADD, SUB, AND, OR, MUL, DIV,
        input  Rout, Rin, Done, Illegal
    );

    modport slave (
        input  Run, Mem_ready, IR,
        output PCout, MDRout, Zhiout, Zlowout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        output IncPC, Read, ADD, SUB, AND, OR, MUL, DIV,
        output Rout, Rin, Done, Illegal
    );
endinterface

// File: rtl/mult_div_control_unit.sv
// Hardwired fetch/execute sequencer for the 32-bit datapath.
// It handles ALU ops, MUL/DIV with LO/HI writeback, a fetch wait on memory, and an iterative DIV hold.
//   IDLE | halted, no strobes          T3 | Rb -> Y, opcode check
//   T0   | PC -> MAR, Z = PC + 1       T4 | Rc + ALU op (DIV holds here)
//   T1   | read memory, PC <= Z        T5 | Zlo -> Ra or LO
//   T2   | MDR -> IR                   T6 | Zhi -> HI
module mult_div_control_unit #(
    parameter int         DIV_CYCLES = 4,
    parameter logic [4:0] OP_ADD     = 5'd0,
    parameter logic [4:0] OP_SUB     = 5'd1,
    parameter logic [4:0] OP_MUL     = 5'd3,
    parameter logic [4:0] OP_DIV     = 5'd4,
    parameter logic [4:0] OP_AND     = 5'd5,
    parameter logic [4:0] OP_OR      = 5'd6
) (
    input logic                     Clock,
    input logic                     Clear,
    mult_div_control_unit_if.slave  bus
);
    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] div_cnt;
    logic [4:0]    op;
    logic [3:0]    ra, rb, rc;
    logic          is_mul, is_div, legal, long_op;
    logic          unused_ir_bits;

    assign op = bus.IR[31:27];
    assign ra = bus.IR[26:23];
    assign rb = bus.IR[22:19];
    assign rc = bus.IR[18:15];
    assign unused_ir_bits = ^bus.IR[14:0];

    assign is_mul  = (op == OP_MUL);
    assign is_div  = (op == OP_DIV);
    assign long_op = is_mul | is_div;
    assign legal   = (op == OP_ADD) | (op == OP_SUB) | (op == OP_AND) |
                     (op == OP_OR)  | long_op;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state   <= IDLE;
            div_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == T3 && is_div)
                div_cnt <= CW'(DIV_CYCLES - 1);
            else if (state == T4 && div_cnt != '0)
                div_cnt <= div_cnt - 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = bus.Run ? T0 : IDLE;
            T0:      state_nx = T1;
            T1:      state_nx = bus.Mem_ready ? T2 : T1;
            T2:      state_nx = T3;
            T3:      state_nx = legal ? T4 : (bus.Run ? T0 : IDLE);
            T4:      state_nx = (is_div && div_cnt != '0) ? T4 : T5;
            T5:      state_nx = long_op ? T6 : (bus.Run ? T0 : IDLE);
            T6:      state_nx = bus.Run ? T0 : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.PCout = 1'b0; bus.MDRout = 1'b0; bus.Zhiout = 1'b0; bus.Zlowout = 1'b0;
        bus.MARin = 1'b0; bus.PCin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0;
        bus.Yin = 1'b0; bus.Zin = 1'b0; bus.HIin = 1'b0; bus.LOin = 1'b0;
        bus.IncPC = 1'b0; bus.Read = 1'b0;
        bus.ADD = 1'b0; bus.SUB = 1'b0; bus.AND = 1'b0; bus.OR = 1'b0;
        bus.MUL = 1'b0; bus.DIV = 1'b0;
        bus.Rout = '0; bus.Rin = '0;
        bus.Done = 1'b0; bus.Illegal = 1'b0;
        unique case (state)
            T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
            end
            T1: begin
                bus.Read    = 1'b1;
                bus.Zlowout = bus.Mem_ready;
                bus.PCin    = bus.Mem_ready;
                bus.MDRin   = bus.Mem_ready;
            end
            T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            T3: begin
                if (legal) begin
                    bus.Rout = 16'd1 << rb;
                    bus.Yin  = 1'b1;
                end else begin
                    bus.Illegal = 1'b1;
                end
            end
            T4: begin
                bus.Rout = 16'd1 << rc;
                bus.ADD  = (op == OP_ADD);
                bus.SUB  = (op == OP_SUB);
                bus.AND  = (op == OP_AND);
                bus.OR   = (op == OP_OR);
                bus.MUL  = is_mul;
                bus.DIV  = is_div;
                // The divider result is only captured once the hold count expires.
                bus.Zin  = !is_div || (div_cnt == '0);
            end
            T5: begin
                bus.Zlowout = 1'b1;
                if (long_op) begin
                    bus.LOin = 1'b1;
                end else begin
                    bus.Rin  = 16'd1 << ra;
                    bus.Done = 1'b1;
                end
            end
            T6: begin
                bus.Zhiout = 1'b1; bus.HIin = 1'b1; bus.Done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mult_div_control_unit.sv
// Directed bench for mult_div_control_unit: cycle-by-cycle strobe checks for MUL, ADD, fetch wait, DIV, illegal, halt, reset.
module tb_mult_div_control_unit;
    logic Clock = 1'b0;
    logic Clear;
    int   checks = 0;
    int   errors = 0;

    mult_div_control_unit_if bus();

    mult_div_control_unit #(.DIV_CYCLES(4)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    localparam logic [21:0] PCOUT = 22'd1 << 21, MDROUT = 22'd1 << 20, ZHIOUT = 22'd1 << 19,
                            ZLOOUT = 22'd1 << 18, MARIN = 22'd1 << 17, PCIN = 22'd1 << 16,
                            MDRIN = 22'd1 << 15, IRIN = 22'd1 << 14, YIN = 22'd1 << 13,
                            ZIN = 22'd1 << 12, HIIN = 22'd1 << 11, LOIN = 22'd1 << 10,
                            INCPC = 22'd1 << 9, READ = 22'd1 << 8, S_ADD = 22'd1 << 7,
                            S_SUB = 22'd1 << 6, S_AND = 22'd1 << 5, S_OR = 22'd1 << 4,
                            S_MUL = 22'd1 << 3, S_DIV = 22'd1 << 2, DONE = 22'd1 << 1,
                            ILLEGAL = 22'd1;
    localparam logic [21:0] FETCH0 = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [21:0] FETCH1 = READ | ZLOOUT | PCIN | MDRIN;
    localparam logic [21:0] FETCH2 = MDROUT | IRIN;

    logic [21:0] strobes;
    assign strobes = {bus.PCout, bus.MDRout, bus.Zhiout, bus.Zlowout, bus.MARin, bus.PCin,
                      bus.MDRin, bus.IRin, bus.Yin, bus.Zin, bus.HIin, bus.LOin, bus.IncPC,
                      bus.Read, bus.ADD, bus.SUB, bus.AND, bus.OR, bus.MUL, bus.DIV,
                      bus.Done, bus.Illegal};

    // Called at posedge+2 with inputs already set. Checks at +3, then moves to the next posedge+2.
    task automatic cyc(input string tag, input logic [21:0] es,
                       input logic [15:0] erout, input logic [15:0] erin);
        #1;
        checks++;
        assert (strobes === es) else begin
            errors++;
            $error("FAIL %s strobes observed %h expected %h", tag, strobes, es);
        end
        checks++;
        assert (bus.Rout === erout) else begin
            errors++;
            $error("FAIL %s Rout observed %h expected %h", tag, bus.Rout, erout);
        end
        checks++;
        assert (bus.Rin === erin) else begin
            errors++;
            $error("FAIL %s Rin observed %h expected %h", tag, bus.Rin, erin);
        end
        @(posedge Clock);
        #2;
    endtask

    task automatic fetch(input string tag);
        cyc({tag, "_t0"}, FETCH0, 16'h0, 16'h0);
        cyc({tag, "_t1"}, FETCH1, 16'h0, 16'h0);
        cyc({tag, "_t2"}, FETCH2, 16'h0, 16'h0);
    endtask

    initial begin
        Clear = 1'b0;
        bus.Run = 1'b0;
        bus.Mem_ready = 1'b1;
        bus.IR = 32'h1A920000;
        @(posedge Clock);
        #2;
        cyc("reset", 22'h0, 16'h0, 16'h0);
        Clear = 1'b1;
        cyc("idle_hold", 22'h0, 16'h0, 16'h0);
        bus.Run = 1'b1;
        cyc("idle_go", 22'h0, 16'h0, 16'h0);

        // MUL r5 = r2 * r4
        fetch("mul");
        cyc("mul_t3", YIN, 16'h0004, 16'h0);
        cyc("mul_t4", S_MUL | ZIN, 16'h0010, 16'h0);
        cyc("mul_t5", ZLOOUT | LOIN, 16'h0, 16'h0);
        cyc("mul_t6", ZHIOUT | HIIN | DONE, 16'h0, 16'h0);

        // ADD r1 = r2 + r3
        bus.IR = 32'h00918000;
        fetch("add");
        cyc("add_t3", YIN, 16'h0004, 16'h0);
        cyc("add_t4", S_ADD | ZIN, 16'h0008, 16'h0);
        cyc("add_t5", ZLOOUT | DONE, 16'h0, 16'h0002);

        // OR r15 = r0 | r14, with a three-cycle memory wait
        bus.IR = {5'd6, 4'd15, 4'd0, 4'd14, 15'd0};
        cyc("wait_t0", FETCH0, 16'h0, 16'h0);
        bus.Mem_ready = 1'b0;
        cyc("wait_t1a", READ, 16'h0, 16'h0);
        cyc("wait_t1b", READ, 16'h0, 16'h0);
        cyc("wait_t1c", READ, 16'h0, 16'h0);
        bus.Mem_ready = 1'b1;
        cyc("wait_t1d", FETCH1, 16'h0, 16'h0);
        cyc("wait_t2", FETCH2, 16'h0, 16'h0);
        cyc("or_t3", YIN, 16'h0001, 16'h0);
        cyc("or_t4", S_OR | ZIN, 16'h4000, 16'h0);
        cyc("or_t5", ZLOOUT | DONE, 16'h0, 16'h8000);

        // DIV r7: r8 / r9, held four cycles in T4
        bus.IR = {5'd4, 4'd7, 4'd8, 4'd9, 15'd0};
        fetch("div");
        cyc("div_t3", YIN, 16'h0100, 16'h0);
        cyc("div_t4a", S_DIV, 16'h0200, 16'h0);
        cyc("div_t4b", S_DIV, 16'h0200, 16'h0);
        cyc("div_t4c", S_DIV, 16'h0200, 16'h0);
        cyc("div_t4d", S_DIV | ZIN, 16'h0200, 16'h0);
        cyc("div_t5", ZLOOUT | LOIN, 16'h0, 16'h0);
        cyc("div_t6", ZHIOUT | HIIN | DONE, 16'h0, 16'h0);

        // Unrecognised opcode
        bus.IR = {5'h1F, 4'd3, 4'd4, 4'd5, 15'd0};
        fetch("ill");
        cyc("ill_t3", ILLEGAL, 16'h0, 16'h0);

        // AND r2 = r6 & r10
        bus.IR = {5'd5, 4'd2, 4'd6, 4'd10, 15'd0};
        fetch("and");
        cyc("and_t3", YIN, 16'h0040, 16'h0);
        cyc("and_t4", S_AND | ZIN, 16'h0400, 16'h0);
        cyc("and_t5", ZLOOUT | DONE, 16'h0, 16'h0004);

        // SUB r3 = r4 - r5, Run dropped mid-instruction
        bus.IR = {5'd1, 4'd3, 4'd4, 4'd5, 15'd0};
        fetch("sub");
        cyc("sub_t3", YIN, 16'h0010, 16'h0);
        bus.Run = 1'b0;
        cyc("sub_t4", S_SUB | ZIN, 16'h0020, 16'h0);
        cyc("sub_t5", ZLOOUT | DONE, 16'h0, 16'h0008);
        cyc("halt_idle1", 22'h0, 16'h0, 16'h0);
        cyc("halt_idle2", 22'h0, 16'h0, 16'h0);

        // Clear asserted during the DIV hold
        bus.Run = 1'b1;
        bus.IR = {5'd4, 4'd7, 4'd8, 4'd9, 15'd0};
        cyc("rdiv_idle", 22'h0, 16'h0, 16'h0);
        fetch("rdiv");
        cyc("rdiv_t3", YIN, 16'h0100, 16'h0);
        cyc("rdiv_t4a", S_DIV, 16'h0200, 16'h0);
        cyc("rdiv_t4b", S_DIV, 16'h0200, 16'h0);
        Clear = 1'b0;
        cyc("rdiv_clear", 22'h0, 16'h0, 16'h0);
        Clear = 1'b1;
        cyc("rdiv_release", 22'h0, 16'h0, 16'h0);
        fetch("rdiv2");
        cyc("rdiv2_t3", YIN, 16'h0100, 16'h0);
        cyc("rdiv2_t4a", S_DIV, 16'h0200, 16'h0);
        cyc("rdiv2_t4b", S_DIV, 16'h0200, 16'h0);
        cyc("rdiv2_t4c", S_DIV, 16'h0200, 16'h0);
        cyc("rdiv2_t4d", S_DIV | ZIN, 16'h0200, 16'h0);
        cyc("rdiv2_t5", ZLOOUT | LOIN, 16'h0, 16'h0);
        cyc("rdiv2_t6", ZHIOUT | HIIN | DONE, 16'h0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
